// File: rtl/counter_param.sv
// counter_param
//   Parametrised up/down counter for credit, occupancy and pointer tracking.
//   Each cycle the counter can reload a new base, add a step and subtract a
//   step. The result either wraps modulo MAX_VALUE+1 or clamps to
//   [0, MAX_VALUE]. Overflow and underflow are sticky flags. is_max and
//   is_zero are registered, so they line up with value.
//
// Ports
//   clk            in   1           clock, rising edge
//   rst            in   1           asynchronous reset, active-high
//   reinit         in   1           use initial_value as the base this cycle
//   initial_value  in   WIDTH       reload value, clamped to MAX_VALUE
//   incr_valid     in   1           qualifies incr
//   incr           in   STEP_WIDTH  increment amount
//   decr_valid     in   1           qualifies decr
//   decr           in   STEP_WIDTH  decrement amount
//   clear_flags    in   1           clears overflow/underflow (a new set wins)
//   value          out  WIDTH       registered count
//   value_next     out  WIDTH       combinational next count
//   overflow       out  1           sticky: a result exceeded MAX_VALUE
//   underflow      out  1           sticky: a result went below zero
//   is_max         out  1           registered value == MAX_VALUE
//   is_zero        out  1           registered value == 0
//
// Handshake: incr_valid/decr_valid qualify their amounts for a single cycle.
// There is no ready signal, because every qualified step is consumed at the
// next rising edge.
module counter_param #(
  parameter int WIDTH       = 4,
  parameter int STEP_WIDTH  = 2,
  parameter int MAX_VALUE   = 2**WIDTH - 1,
  parameter int SATURATE    = 0,
  parameter int RESET_VALUE = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  reinit,
  input  logic [WIDTH-1:0]      initial_value,
  input  logic                  incr_valid,
  input  logic [STEP_WIDTH-1:0] incr,
  input  logic                  decr_valid,
  input  logic [STEP_WIDTH-1:0] decr,
  input  logic                  clear_flags,
  output logic [WIDTH-1:0]      value,
  output logic [WIDTH-1:0]      value_next,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  is_max,
  output logic                  is_zero
);

  // Two guard bits hold base + step (at most 2*MAX_VALUE) and base - step
  // (at least -MAX_VALUE) without truncation.
  localparam int SW = WIDTH + 2;
  localparam logic signed [SW-1:0] MAX_S = SW'(MAX_VALUE);
  localparam logic signed [SW-1:0] MOD_S = SW'(MAX_VALUE + 1);
  localparam logic [WIDTH-1:0]     MAX_U = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0]     RST_U = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0]     value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic                 is_max_q, is_max_d;
  logic                 is_zero_q, is_zero_d;

  logic signed [SW-1:0] init_s;
  logic signed [SW-1:0] base_s;
  logic signed [SW-1:0] inc_s;
  logic signed [SW-1:0] dec_s;
  logic signed [SW-1:0] sum_s;
  logic signed [SW-1:0] result_s;
  logic                 step_active;
  logic                 sum_over;
  logic                 sum_under;

  always_comb begin
    init_s = signed'(SW'(initial_value));
    if (init_s > MAX_S) begin
      init_s = MAX_S;
    end
    base_s = reinit     ? init_s : signed'(SW'(value_q));
    inc_s  = incr_valid ? signed'(SW'(incr)) : '0;
    dec_s  = decr_valid ? signed'(SW'(decr)) : '0;
    // The net step is applied in one go, so the intermediate is never checked.
    sum_s  = base_s + inc_s - dec_s;

    sum_over  = (sum_s > MAX_S);
    sum_under = sum_s[SW-1];

    result_s = sum_s;
    if (sum_over) begin
      result_s = (SATURATE != 0) ? MAX_S : (sum_s - MOD_S);
    end else if (sum_under) begin
      result_s = (SATURATE != 0) ? '0 : (sum_s + MOD_S);
    end

    step_active = reinit | incr_valid | decr_valid;
    value_d     = step_active ? result_s[WIDTH-1:0] : value_q;

    // A flag set in the same cycle takes priority over clear_flags.
    ovf_d = (step_active & sum_over)  | (ovf_q & ~clear_flags);
    unf_d = (step_active & sum_under) | (unf_q & ~clear_flags);

    is_max_d  = (value_d == MAX_U);
    is_zero_d = (value_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q   <= RST_U;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      is_max_q  <= (RST_U == MAX_U);
      is_zero_q <= (RST_U == '0);
    end else begin
      value_q   <= value_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      is_max_q  <= is_max_d;
      is_zero_q <= is_zero_d;
    end
  end

  assign value      = value_q;
  assign value_next = value_d;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign is_max     = is_max_q;
  assign is_zero    = is_zero_q;

endmodule
